tc_rr_arbiter4: RTL and testbench
=================================

Name: tc_rr_arbiter4

Overview:
- 4-requester round-robin arbiter.
- Produces a registered 2-bit grant index on sel1/sel0 plus a valid flag.
- Sits directly upstream of the 2-to-4 one-hot decoder. The decoder's out0..out3, gated with valid, form the one-hot grant bus to the shared resource.
- The grant is held while the owner keeps its request high. Next owner is chosen round-robin, starting after the last winner.

Parameters:
- START_PTR, 0: index (0..3) searched first after reset.
- MAX_HOLD, 8: maximum consecutive cycles one owner may hold the grant while others wait. Active only with TC_ARB_MAXHOLD_EN. Legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- req0  input  1  request from requester 0
- req1  input  1  request from requester 1
- req2  input  1  request from requester 2
- req3  input  1  request from requester 3
- sel0  output  1  grant index bit 0 (registered)
- sel1  output  1  grant index bit 1 (registered)
- valid  output  1  1 = {sel1,sel0} names the current owner
- new_grant  output  1  one-cycle pulse on the first cycle of each new grant

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, including mid-grant):
  - outputs: sel1,sel0=00, valid=0, new_grant=0
  - internal: state=IDLE, ptr=START_PTR, hold_cnt=0
- Arbitration function:
  - Scans req[ptr], req[ptr+1], req[ptr+2], req[ptr+3], indices mod 4 (2-bit wrap, 3+1=0).
  - The first asserted request wins.
  - On every grant: ptr <= winner+1 mod 4.
- State IDLE:
  - No request: stay in IDLE, valid=0, sel unchanged (holds the last owner).
  - Any request sampled at edge N: at edge N+1 set sel=winner, valid=1, new_grant=1, state=BUSY. Latency from request to valid is 1 cycle.
- State BUSY, owner = {sel1,sel0}:
  - req[owner]=1: hold. sel is stable, valid=1, new_grant=0.
  - req[owner]=0 and some other req=1: regrant at the next edge with no idle cycle. new_grant=1, valid stays 1.
  - req[owner]=0 and no req: next edge sets valid=0, state=IDLE, sel unchanged.
- Requests are level-sensitive and sampled only at rising edges. A request that rises and falls between edges is lost.
- The owner cannot win a back-to-back regrant against itself, because its req is low when the regrant is decided.
- new_grant is exactly 1 cycle wide. It never asserts while valid=0.
- Simultaneous requests while IDLE: a single winner, chosen by the ptr rotation. Losers stay pending; they are not latched, so the requester must keep req high.
- valid=0 implies new_grant=0. Decoder outputs are meaningless while valid=0.

Optional Feature:
- Macro: TC_ARB_MAXHOLD_EN.
- Defined:
  - hold_cnt (8 bits) is cleared on every new grant and increments each BUSY cycle with no new grant.
  - When hold_cnt reaches MAX_HOLD-1 and any non-owner req=1, the next edge forces a regrant to the round-robin winner, excluding the owner, even though req[owner]=1. new_grant pulses.
  - If no other request is pending, the owner keeps the grant and hold_cnt saturates at MAX_HOLD-1.
  - The preempted owner re-competes normally.
- Undefined: no hold_cnt logic. A grant is held indefinitely while req[owner]=1.

Test Plan:
- Reset state: rst=0 with req0..3=1111 -> sel=00, valid=0, new_grant=0. Release rst -> next edge sel=00, valid=1, new_grant=1.
- Rotation: req=1111, each owner drops its req for 1 cycle after grant and re-raises it -> owner sequence 0,1,2,3,0, one new_grant per change.
- Back-to-back handover: owner 2 holds; req1 and req3 high; req2 falls -> next edge sel=11, new_grant=1, valid never drops.
- Idle return: sole owner 1 drops req, no others -> next edge valid=0, sel=01 retained. Then req0=1 -> sel=00, valid=1 one cycle later.
- Async reset mid-grant: rst low between edges while valid=1, sel=10 -> outputs 00/0/0 immediately without a clock. After release, ptr=START_PTR.
- TC_ARB_MAXHOLD_EN with MAX_HOLD=4: req0 held high and req2 high -> owner 0 for exactly 4 cycles, then sel=10 with new_grant=1. With only req0 high, owner 0 keeps the grant beyond 4 cycles.

Source files
------------

// File: rtl/tc_rr_arbiter4.sv
// ---------------------------------------------------------------------------
// tc_rr_arbiter4 - 4-requester round-robin arbiter
//
// Purpose:
//   Grants one of four level-sensitive requesters and reports the owner as a
//   registered 2-bit index {sel1,sel0} plus a valid flag. A grant is held
//   while the owner keeps its request high. The next owner is found by a
//   rotating search that starts just after the last winner. A downstream
//   2-to-4 decoder, gated with valid, turns the index into a one-hot grant.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   asynchronous active-low reset (0 = reset)
//   req0..3    in   request lines, sampled at rising edges
//   sel0/sel1  out  registered grant index (holds last owner while idle)
//   valid      out  1 = {sel1,sel0} names the current owner
//   new_grant  out  one-cycle pulse on the first cycle of every new grant
//
// Parameters:
//   START_PTR  index searched first after reset (0..3)
//   MAX_HOLD   owner hold limit while others wait (1..255); only used when
//              the macro TC_ARB_MAXHOLD_EN is defined
//
// Optional feature (macro TC_ARB_MAXHOLD_EN):
//   Defined   - an 8-bit hold counter forces a handover once the owner has
//               held for MAX_HOLD cycles and another requester is waiting.
//   Undefined - the owner keeps the grant for as long as its request stays
//               high.
// ---------------------------------------------------------------------------
module tc_rr_arbiter4 #(
  parameter int START_PTR = 0,
  parameter int MAX_HOLD  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  output logic sel0,
  output logic sel1,
  output logic valid,
  output logic new_grant
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Catch illegal parameter values at elaboration time.
  if (START_PTR < 0 || START_PTR > 3) begin : g_bad_start_ptr
    $error("tc_rr_arbiter4: START_PTR must be 0..3");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("tc_rr_arbiter4: MAX_HOLD must be 1..255");
  end

  state_t      state_reg;
  logic [1:0]  ptr_reg;
  logic [1:0]  sel_reg;
  logic        valid_reg;
  logic        new_grant_reg;

  logic [3:0]  req;
  logic [3:0]  own_mask;
  logic [3:0]  req_eff;
  logic [3:0]  rot;
  logic [1:0]  offset;
  logic [1:0]  winner;
  logic        owner_req;
  logic        others_req;
  logic        preempt;
  logic        grant;

  assign req = {req3, req2, req1, req0};

  // One-hot mask of the current owner, used to exclude it from the search.
  assign own_mask   = 4'b0001 << sel_reg;
  assign owner_req  = |(req & own_mask);
  assign others_req = |(req & ~own_mask);

  // While busy the owner never competes: either its request is already low
  // (normal handover) or it is being preempted by the hold limit.
  assign req_eff = (state_reg == BUSY) ? (req & ~own_mask) : req;

  // Rotate the candidates so that rot[0] is the requester at ptr, rot[1]
  // the next one, and so on with 2-bit wrap.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign rot[gi] = req_eff[ptr_reg + 2'(gi)];
  end

  // Lowest set bit of the rotated vector is the first requester after ptr.
  always_comb begin
    offset = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) offset = 2'(i);
    end
  end

  assign winner = ptr_reg + offset;

`ifdef TC_ARB_MAXHOLD_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt_reg;

  assign preempt = (state_reg == BUSY) && owner_req && others_req &&
                   (hold_cnt_reg == HOLD_LAST);

  // Cleared on every new grant, counts held cycles, saturates at the limit
  // when nobody else is waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt_reg <= 8'd0;
    end else if (grant || state_reg != BUSY) begin
      hold_cnt_reg <= 8'd0;
    end else if (hold_cnt_reg != HOLD_LAST) begin
      hold_cnt_reg <= hold_cnt_reg + 8'd1;
    end
  end
`else
  assign preempt = 1'b0;
`endif

  assign grant = (state_reg == IDLE) ? (|req)
               : ((!owner_req || preempt) && others_req);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= 2'(START_PTR);
      sel_reg       <= 2'b00;
      valid_reg     <= 1'b0;
      new_grant_reg <= 1'b0;
    end else if (grant) begin
      state_reg     <= BUSY;
      ptr_reg       <= winner + 2'd1;
      sel_reg       <= winner;
      valid_reg     <= 1'b1;
      new_grant_reg <= 1'b1;
    end else if (state_reg == BUSY && owner_req) begin
      new_grant_reg <= 1'b0;
    end else begin
      // No request anywhere: drop valid but keep sel on the last owner.
      state_reg     <= IDLE;
      valid_reg     <= 1'b0;
      new_grant_reg <= 1'b0;
    end
  end

  assign sel0      = sel_reg[0];
  assign sel1      = sel_reg[1];
  assign valid     = valid_reg;
  assign new_grant = new_grant_reg;

endmodule

// File: tb/tb_tc_rr_arbiter4.sv
// ---------------------------------------------------------------------------
// tb_tc_rr_arbiter4 - directed self-checking bench for tc_rr_arbiter4
//
// Drives a linear sequence of request patterns and compares
// {sel1,sel0,valid,new_grant} against hand-computed values. Inputs change
// 1 ns after a rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_tc_rr_arbiter4;

`ifdef TC_ARB_MAXHOLD_EN
  localparam int MH = 4;
`else
  localparam int MH = 8;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       sel0;
  logic       sel1;
  logic       valid;
  logic       new_grant;

  int n_asserts = 0;
  int n_fail    = 0;

  tc_rr_arbiter4 #(
    .START_PTR (0),
    .MAX_HOLD  (MH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req[0]),
    .req1      (req[1]),
    .req2      (req[2]),
    .req3      (req[3]),
    .sel0      (sel0),
    .sel1      (sel1),
    .valid     (valid),
    .new_grant (new_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] es,
                     input logic ev, input logic eng);
    logic [3:0] obs;
    logic [3:0] exp;
    obs = {sel1, sel0, valid, new_grant};
    exp = {es, ev, eng};
    n_asserts++;
    $display("[%0t] %s req=%b sel=%b valid=%b new_grant=%b", $time, tag,
             req, {sel1, sel0}, valid, new_grant);
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed sel/valid/new_grant=%b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    req = 4'b1111;

    // Reset state with every request active
    #3;
    chk("reset_t0", 2'b00, 1'b0, 1'b0);
    tick();
    chk("reset_edge1", 2'b00, 1'b0, 1'b0);
    tick();
    chk("reset_edge2", 2'b00, 1'b0, 1'b0);

    // Release: first edge grants START_PTR
    rst = 1'b1;
    tick();
    chk("release_grant0", 2'b00, 1'b1, 1'b1);

    // Rotation: each owner drops for one cycle
    req = 4'b1110; tick(); chk("rot_1", 2'b01, 1'b1, 1'b1);
    req = 4'b1101; tick(); chk("rot_2", 2'b10, 1'b1, 1'b1);
    req = 4'b1011; tick(); chk("rot_3", 2'b11, 1'b1, 1'b1);
    req = 4'b0111; tick(); chk("rot_0", 2'b00, 1'b1, 1'b1);
    req = 4'b1111; tick(); chk("rot_hold0", 2'b00, 1'b1, 1'b0);

    // Back-to-back handover 2 -> 3 (ptr=1 after owner 0)
    req = 4'b0100; tick(); chk("hand_own2", 2'b10, 1'b1, 1'b1);
    req = 4'b1110; tick(); chk("hand_hold2", 2'b10, 1'b1, 1'b0);
    req = 4'b1010; tick(); chk("hand_to3", 2'b11, 1'b1, 1'b1);

    // Idle return with owner 1 retained on sel
    req = 4'b0010; tick(); chk("idle_own1", 2'b01, 1'b1, 1'b1);
    tick();              chk("idle_hold1", 2'b01, 1'b1, 1'b0);
    req = 4'b0000; tick(); chk("idle_drop", 2'b01, 1'b0, 1'b0);
    tick();              chk("idle_stay", 2'b01, 1'b0, 1'b0);
    req = 4'b0001; tick(); chk("idle_req0", 2'b00, 1'b1, 1'b1);

    // A pulse between edges is lost
    req = 4'b0000; tick(); chk("pulse_idle", 2'b00, 1'b0, 1'b0);
    req = 4'b1000; #2; req = 4'b0000;
    tick();              chk("pulse_lost", 2'b00, 1'b0, 1'b0);

    // Async reset mid-grant with owner 2 (ptr=1 here)
    req = 4'b0100; tick(); chk("arst_own2", 2'b10, 1'b1, 1'b1);
    tick();              chk("arst_hold2", 2'b10, 1'b1, 1'b0);
    #2; rst = 1'b0; #1;
    chk("arst_async", 2'b00, 1'b0, 1'b0);
    req = 4'b1100;
    tick();              chk("arst_in_reset", 2'b00, 1'b0, 1'b0);
    rst = 1'b1;
    // ptr back at 0 picks 2; a stale ptr of 3 would pick 3
    tick();              chk("arst_ptr_reset", 2'b10, 1'b1, 1'b1);

    // Hold limit: owner 0 with req2 waiting (ptr=1 after grant)
    req = 4'b0001; tick(); chk("mh_own0", 2'b00, 1'b1, 1'b1);
    req = 4'b0101;
`ifdef TC_ARB_MAXHOLD_EN
    tick(); chk("mh_hold_c2", 2'b00, 1'b1, 1'b0);
    tick(); chk("mh_hold_c3", 2'b00, 1'b1, 1'b0);
    tick(); chk("mh_hold_c4", 2'b00, 1'b1, 1'b0);
    tick(); chk("mh_preempt", 2'b10, 1'b1, 1'b1);
`else
    for (int i = 0; i < 12; i++) begin
      tick(); chk("nohold_limit", 2'b00, 1'b1, 1'b0);
    end
    // Owner 0 releases, waiting requester 2 takes over
    req = 4'b0100; tick(); chk("nohold_to2", 2'b10, 1'b1, 1'b1);
`endif

    // Sole requester 0 keeps the grant beyond the hold limit
    req = 4'b0001; tick(); chk("solo_own0", 2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(); chk("solo_hold0", 2'b00, 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
